bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive cycles one source may own the internal data bus.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  10  bus requests; bit i requests the internal 8-bit bus for source i (data_i of the bus multiplexer).
REQ-005 hold  input  1  current owner asks to keep the bus next cycle; ignored when no grant is active.
REQ-006 select_0 .. select_9  output  1 each  one-hot source selects, wired directly to the bus multiplexer's select_0..select_9.
REQ-007 gnt_valid  output  1  high when exactly one select is asserted.
REQ-008 gnt_id  output  4  binary index (0-9) of the current owner; 0 when gnt_valid is low.

Function
REQ-009 All outputs SHALL be registered; no output depends combinationally on req or hold.
REQ-010 select_0..select_9 SHALL be one-hot or all-zero in every cycle; an all-zero bus drives 8'h00 through the multiplexer.
REQ-011 States: IDLE (no owner) and OWN (one owner, hold counter active).
REQ-012 IDLE: if any req bit is high at a rising edge, move to OWN and assert the winner's select on that edge (1-cycle latency); otherwise stay in IDLE with all selects low.
REQ-013 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod 10 and wraps from 9 to 0; the first requesting index wins.
REQ-014 The round-robin pointer SHALL update to the winner's index on every new grant.
REQ-015 OWN: hold counter is loaded with 1 on grant and increments each cycle ownership continues.
REQ-016 OWN: if hold=1, req[owner]=1 and counter<MAX_HOLD, ownership SHALL continue with no change to the selects.
REQ-017 OWN: otherwise, release at the edge: if other requests (or the owner's own request) are pending, grant the next round-robin winner on the same edge (back-to-back, no idle bubble); if none are pending, return to IDLE.
REQ-018 Forced release at counter=MAX_HOLD SHALL exclude the current owner from that edge's search unless it is the only requester.
REQ-019 Owner dropping req while holding SHALL release the bus at the next edge regardless of hold.
REQ-020 gnt_id and gnt_valid SHALL always be consistent with the select outputs in the same cycle.
REQ-021 MAX_HOLD=1 SHALL make hold ineffective: every grant lasts exactly one cycle.

Reset
REQ-022 On reset assertion, immediately and without waiting for clk: all selects 0, gnt_valid 0, gnt_id 0, state IDLE, hold counter 0, round-robin pointer 9 (first search starts at index 0).
REQ-023 Reset asserted mid-ownership SHALL drop the grant at once; after deassertion, arbitration resumes from the reset pointer on the first rising edge.
REQ-024 req and hold SHALL be ignored while reset is high.

Structure
REQ-025 Shared package SHALL hold NUM_SOURCES=10, ID_WIDTH=4, the default MAX_HOLD, and the state encoding constants IDLE/OWN.
REQ-026 One sub-module, rr_pick (combinational round-robin priority search: req, pointer, exclude mask -> winner index and found flag), SHALL be instantiated once.
REQ-027 A one-hot to binary conversion for gnt_id SHALL be derived from the same registered winner index, not re-encoded from the selects.

Verification
REQ-028 Reset, then req=10'h001 for 1 cycle -> select_0=1, gnt_id=0 one edge later; all selects 0 on the following edge.
REQ-029 req=10'h3FF held constantly, hold=0 -> grants cycle 0,1,...,9,0 on successive edges with no idle cycle.
REQ-030 req[3]=1, hold=1, MAX_HOLD=4, req[5]=1 -> owner 3 for exactly 4 cycles, then owner 5; with req[5]=0, owner 3 is re-granted after the forced release.
REQ-031 Owner 7 with hold=1 drops req[7] -> bus released on the next edge; gnt_valid=0 if nothing else requests.
REQ-032 Reset pulsed mid-ownership of source 4, between clock edges -> selects go 0 before the next edge; req=10'h3FF after release -> first grant is index 0.
REQ-033 Random req/hold for 10^5 cycles -> selects are never multi-hot, no requester waits more than 9*MAX_HOLD cycles, and gnt_id matches the selects.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 10-source bus arbiter.
package bus_arbiter_pkg;

    localparam int NUM_SOURCES      = 10;
    localparam int ID_WIDTH         = 4;
    localparam int DEFAULT_MAX_HOLD = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic logic [NUM_SOURCES-1:0] onehot(input logic [ID_WIDTH-1:0] id);
        logic [NUM_SOURCES-1:0] one;
        one    = NUM_SOURCES'(1);
        onehot = one << id;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index after the pointer, wrapping 9 -> 0.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [ID_WIDTH-1:0]    pointer,
    input  logic [NUM_SOURCES-1:0] exclude,
    output logic [ID_WIDTH-1:0]    winner,
    output logic                   found
);

    logic [NUM_SOURCES-1:0] eligible;
    logic [ID_WIDTH:0]      sum;
    logic [ID_WIDTH-1:0]    cand;

    // Offsets 1..NUM_SOURCES so the pointer itself is examined last.
    always_comb begin
        eligible = req & ~exclude;
        winner   = '0;
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_SOURCES; i++) begin
            sum  = {1'b0, pointer} + (ID_WIDTH+1)'(i);
            cand = (sum >= (ID_WIDTH+1)'(NUM_SOURCES)) ?
                   ID_WIDTH'(sum - (ID_WIDTH+1)'(NUM_SOURCES)) : sum[ID_WIDTH-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the internal 8-bit bus with bounded hold and one-hot registered selects.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] req,
    input  logic                   hold,
    output logic                   select_0,
    output logic                   select_1,
    output logic                   select_2,
    output logic                   select_3,
    output logic                   select_4,
    output logic                   select_5,
    output logic                   select_6,
    output logic                   select_7,
    output logic                   select_8,
    output logic                   select_9,
    output logic                   gnt_valid,
    output logic [ID_WIDTH-1:0]    gnt_id
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_t                 state;
    logic [ID_WIDTH-1:0]    owner;
    logic [ID_WIDTH-1:0]    pointer;
    logic [CNT_W-1:0]       hold_cnt;
    logic [NUM_SOURCES-1:0] sel;

    logic [NUM_SOURCES-1:0] owner_mask;
    logic [NUM_SOURCES-1:0] exclude;
    logic                   keep;
    logic                   forced;
    logic [ID_WIDTH-1:0]    pick_id;
    logic                   pick_found;

    // The owner is skipped on a forced release only when someone else is waiting.
    always_comb begin
        owner_mask = onehot(owner);
        keep       = (state == OWN) && hold && req[owner] && (hold_cnt < CNT_W'(MAX_HOLD));
        forced     = (state == OWN) && hold && req[owner] && (hold_cnt == CNT_W'(MAX_HOLD));
        exclude    = (forced && |(req & ~owner_mask)) ? owner_mask : '0;
    end

    rr_pick u_rr_pick (
        .req     (req),
        .pointer (pointer),
        .exclude (exclude),
        .winner  (pick_id),
        .found   (pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            pointer   <= ID_WIDTH'(NUM_SOURCES - 1);
            hold_cnt  <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
        end else if (keep) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end else if (pick_found) begin
            state     <= OWN;
            owner     <= pick_id;
            pointer   <= pick_id;
            hold_cnt  <= CNT_W'(1);
            sel       <= onehot(pick_id);
            gnt_valid <= 1'b1;
        end else begin
            state     <= IDLE;
            owner     <= '0;
            hold_cnt  <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
        end
    end

    // Owner register is cleared whenever the bus is idle, so it doubles as gnt_id.
    assign gnt_id   = owner;
    assign select_0 = sel[0];
    assign select_1 = sel[1];
    assign select_2 = sel[2];
    assign select_3 = sel[3];
    assign select_4 = sel[4];
    assign select_5 = sel[5];
    assign select_6 = sel[6];
    assign select_7 = sel[7];
    assign select_8 = sel[8];
    assign select_9 = sel[9];

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed vectors queue expected grants, a monitor compares them.
module tb_bus_arbiter;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic       valid;
        logic [3:0] id;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] req = '0;
    logic       hold = 1'b0;
    logic       select_0, select_1, select_2, select_3, select_4;
    logic       select_5, select_6, select_7, select_8, select_9;
    logic       gnt_valid;
    logic [3:0] gnt_id;
    logic [9:0] sel;

    exp_t exp_q[$];
    int   checks_total = 0;
    int   checks_passed = 0;
    int   wait_cnt[10];

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .hold      (hold),
        .select_0  (select_0),
        .select_1  (select_1),
        .select_2  (select_2),
        .select_3  (select_3),
        .select_4  (select_4),
        .select_5  (select_5),
        .select_6  (select_6),
        .select_7  (select_7),
        .select_8  (select_8),
        .select_9  (select_9),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel = {select_9, select_8, select_7, select_6, select_5,
                  select_4, select_3, select_2, select_1, select_0};

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic exp_valid, input logic [3:0] exp_id);
        logic [9:0] exp_sel;
        logic [9:0] one;
        one     = 10'd1;
        exp_sel = exp_valid ? (one << exp_id) : 10'd0;
        checks_total++;
        if (sel === exp_sel && gnt_valid === exp_valid && gnt_id === exp_id)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got valid=%b id=%0d sel=%h, expected valid=%b id=%0d sel=%h",
                     name, gnt_valid, gnt_id, sel, exp_valid, exp_id, exp_sel);
    endtask

    // Drive one cycle of inputs; the expected grant appears after the next rising edge.
    task automatic applyStimulus(input string name, input logic [9:0] r, input logic h,
                                 input logic exp_valid, input logic [3:0] exp_id);
        exp_t e;
        @(negedge clk);
        req  = r;
        hold = h;
        e.valid = exp_valid;
        e.id    = exp_id;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        hold  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e.name, e.valid, e.id);
            end
        end
    end

    initial begin : stimulus
        int guard;
        logic ok;
        #3;
        checkOutput("reset_state", 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("single_req0",       10'h001, 1'b0, 1'b1, 4'd0);
        applyStimulus("single_release",    10'h000, 1'b0, 1'b0, 4'd0);
        applyStimulus("idle_hold_ignored", 10'h000, 1'b1, 1'b0, 4'd0);

        resetDut();
        for (int k = 0; k < 11; k++)
            applyStimulus("rr_all", 10'h3FF, 1'b0, 1'b1, 4'(k % 10));
        applyStimulus("rr_drain", 10'h000, 1'b0, 1'b0, 4'd0);

        resetDut();
        for (int k = 0; k < 4; k++) applyStimulus("hold_owner3", 10'h028, 1'b1, 1'b1, 4'd3);
        for (int k = 0; k < 4; k++) applyStimulus("hold_owner5", 10'h028, 1'b1, 1'b1, 4'd5);
        applyStimulus("hold_back3", 10'h028, 1'b1, 1'b1, 4'd3);
        applyStimulus("hold_drain", 10'h000, 1'b0, 1'b0, 4'd0);

        resetDut();
        for (int k = 0; k < 6; k++) applyStimulus("hold_sole3", 10'h008, 1'b1, 1'b1, 4'd3);
        applyStimulus("sole3_drain", 10'h000, 1'b0, 1'b0, 4'd0);

        resetDut();
        applyStimulus("own7",         10'h080, 1'b1, 1'b1, 4'd7);
        applyStimulus("own7_keep",    10'h084, 1'b1, 1'b1, 4'd7);
        applyStimulus("own7_drop",    10'h004, 1'b1, 1'b1, 4'd2);
        applyStimulus("own2_to_idle", 10'h000, 1'b1, 1'b0, 4'd0);
        applyStimulus("own7b",        10'h080, 1'b1, 1'b1, 4'd7);
        applyStimulus("own7b_drop",   10'h000, 1'b1, 1'b0, 4'd0);

        resetDut();
        applyStimulus("own4",      10'h010, 1'b1, 1'b1, 4'd4);
        applyStimulus("own4_keep", 10'h010, 1'b1, 1'b1, 4'd4);
        @(negedge clk);
        #2;
        reset = 1'b1;
        req   = 10'h3FF;
        hold  = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 4'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_ignores_req", 1'b0, 4'd0);
        #1;
        reset = 1'b0;
        hold  = 1'b0;
        applyStimulus("post_reset_grant0", 10'h3FF, 1'b0, 1'b1, 4'd0);
        applyStimulus("post_reset_grant1", 10'h3FF, 1'b0, 1'b1, 4'd1);
        applyStimulus("post_reset_drain",  10'h000, 1'b0, 1'b0, 4'd0);

        // Random traffic: one-hot selects, consistent id and bounded waiting every cycle.
        resetDut();
        for (int i = 0; i < 10; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            req  = 10'($urandom_range(0, 1023));
            hold = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            ok = 1'b1;
            if ($countones(sel) > 1) ok = 1'b0;
            if (gnt_valid !== ($countones(sel) == 1)) ok = 1'b0;
            if (gnt_valid && sel !== (10'd1 << gnt_id)) ok = 1'b0;
            if (!gnt_valid && gnt_id !== 4'd0) ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (req[i] && !sel[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > 9 * MAX_HOLD) ok = 1'b0;
            end
            checks_total++;
            if (ok) checks_passed++;
            else $display("[TB] FAIL random_invariant cycle %0d: got sel=%h valid=%b id=%0d, expected one-hot consistent grant within %0d cycles",
                          c, sel, gnt_valid, gnt_id, 9 * MAX_HOLD);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks_total++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
